// File: rtl/three_to_eight_decoder_if.sv
// ---------------------------------------------------------------------------
// Interface: three_to_eight_decoder_if
//
// Purpose:
//   Bundles the select/enable inputs and the eight one-hot decode lines of the
//   registered 3-to-8 decoder so a control FSM (master) and the decoder
//   (slave) can be connected through a single port.
//
// Signals:
//   enable   master -> slave   decode enable; 0 forces every line idle
//   a0..a2   master -> slave   3-bit select, a0 is the LSB
//   d0..d7   slave  -> master  registered one-hot decode lines
//   valid    slave  -> master  registered "decode was enabled" flag, only
//                              present when DEC_VALID_EN is defined
//
// Configuration macro: DEC_VALID_EN (adds the valid signal and modport entry)
// ---------------------------------------------------------------------------
interface three_to_eight_decoder_if;

    logic enable;
    logic a0;
    logic a1;
    logic a2;

    logic d0;
    logic d1;
    logic d2;
    logic d3;
    logic d4;
    logic d5;
    logic d6;
    logic d7;

`ifdef DEC_VALID_EN
    logic valid;

    modport master (
        output enable, a0, a1, a2,
        input  d0, d1, d2, d3, d4, d5, d6, d7,
        input  valid
    );

    modport slave (
        input  enable, a0, a1, a2,
        output d0, d1, d2, d3, d4, d5, d6, d7,
        output valid
    );
`else
    modport master (
        output enable, a0, a1, a2,
        input  d0, d1, d2, d3, d4, d5, d6, d7
    );

    modport slave (
        input  enable, a0, a1, a2,
        output d0, d1, d2, d3, d4, d5, d6, d7
    );
`endif

endinterface : three_to_eight_decoder_if

// File: rtl/three_to_eight_decoder.sv
// ---------------------------------------------------------------------------
// Module: three_to_eight_decoder
//
// Purpose:
//   Registered 3-to-8 line decoder with enable. The select {a2,a1,a0} is
//   decoded to a one-hot word that is captured on the rising clock edge, so
//   every output is a flop and the decode latency is exactly one cycle.
//   Sits between a control FSM and downstream one-hot (chip-select) users.
//
// Parameters:
//   OUT_ACTIVE_LOW  0: asserted line = 1, idle lines = 0
//                   1: every d line inverted (asserted = 0, idle = 1),
//                      including the value loaded by reset
//
// Ports:
//   clk   in     clock, all state updates on the rising edge
//   rst   in     synchronous reset, active-high, priority over everything
//   bus   slave  three_to_eight_decoder_if: enable, a0..a2 in; d0..d7 out;
//                valid out when DEC_VALID_EN is defined
//
// Configuration macro: DEC_VALID_EN
//   Defined   -> bus.valid is driven: 1 after an edge with rst=0, enable=1,
//                0 otherwise; it is never inverted by OUT_ACTIVE_LOW.
//   Undefined -> no valid signal exists.
// ---------------------------------------------------------------------------
module three_to_eight_decoder #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    three_to_eight_decoder_if.slave       bus
);

    // Level every line sits at when it is not the selected one.
    localparam logic [7:0] IDLE_WORD = {8{OUT_ACTIVE_LOW}};

    logic [2:0] sel;
    logic [7:0] oneHot;
    logic [7:0] d_d;
    logic [7:0] d_q;

    assign sel = {bus.a2, bus.a1, bus.a0};

    // Active-high one-hot decode; all zeros when the decoder is disabled.
    always_comb begin
        oneHot = 8'h00;
        if (bus.enable) begin
            oneHot = 8'h01 << sel;
        end
    end

    // Polarity is applied before the flop so the outputs stay glitch-free
    // registered values in both builds; XOR with the idle word flips every
    // line when the outputs are active-low.
    always_comb begin
        d_d = oneHot ^ IDLE_WORD;
    end

    // Output register; reset loads the idle level regardless of enable/select.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= IDLE_WORD;
        end else begin
            d_q <= d_d;
        end
    end

    assign bus.d0 = d_q[0];
    assign bus.d1 = d_q[1];
    assign bus.d2 = d_q[2];
    assign bus.d3 = d_q[3];
    assign bus.d4 = d_q[4];
    assign bus.d5 = d_q[5];
    assign bus.d6 = d_q[6];
    assign bus.d7 = d_q[7];

`ifdef DEC_VALID_EN
    logic valid_d;
    logic valid_q;

    // valid tracks enable with the same one-cycle timing as the d lines.
    always_comb begin
        valid_d = bus.enable;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign bus.valid = valid_q;
`endif

endmodule : three_to_eight_decoder

// File: tb/tb_three_to_eight_decoder.sv
// ---------------------------------------------------------------------------
// Testbench: tb_three_to_eight_decoder
//
// Purpose:
//   Drives an active-high and an active-low instance of the registered
//   3-to-8 decoder with identical stimulus. Expected results are pushed to a
//   scoreboard queue when stimulus is applied and popped when the registered
//   outputs are sampled one edge later.
//
// Configuration macro: DEC_VALID_EN (also checks the valid output)
// ---------------------------------------------------------------------------
module tb_three_to_eight_decoder;

    typedef struct {
        logic [7:0] dWord;
        logic       valid;
        logic       en;
    } expT;

    logic clk;
    logic rst;

    expT sb[$];
    int  checkCount;
    int  failCount;

    three_to_eight_decoder_if ifH ();
    three_to_eight_decoder_if ifL ();

    three_to_eight_decoder #(.OUT_ACTIVE_LOW(1'b0)) dutHigh (
        .clk (clk),
        .rst (rst),
        .bus (ifH.slave)
    );

    three_to_eight_decoder #(.OUT_ACTIVE_LOW(1'b1)) dutLow (
        .clk (clk),
        .rst (rst),
        .bus (ifL.slave)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] wordOf(input logic d7, d6, d5, d4, d3, d2, d1, d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    // Single comparison point: counts, asserts, and reports on failure.
    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample just after the edge and compare against the oldest expectation.
    task automatic checkOutput(input string tag);
        expT e;
        logic [7:0] obsH;
        logic [7:0] obsL;
        if (sb.size() == 0) begin
            checkCount++;
            failCount++;
            $error("[TB] FAIL %s observed=empty_scoreboard expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        obsH = wordOf(ifH.d7, ifH.d6, ifH.d5, ifH.d4, ifH.d3, ifH.d2, ifH.d1, ifH.d0);
        obsL = wordOf(ifL.d7, ifL.d6, ifL.d5, ifL.d4, ifL.d3, ifL.d2, ifL.d1, ifL.d0);
        compare({tag, "_high"}, obsH, e.dWord);
        compare({tag, "_low"}, obsL, ~e.dWord);
        compare({tag, "_ones"}, 8'($countones(obsH)), (e.en ? 8'd1 : 8'd0));
`ifdef DEC_VALID_EN
        compare({tag, "_validH"}, {7'd0, ifH.valid}, {7'd0, e.valid});
        compare({tag, "_validL"}, {7'd0, ifL.valid}, {7'd0, e.valid});
`endif
    endtask

    // Drive both instances, push the model's expectation, advance one edge
    // and check the registered result.
    task automatic applyStimulus(input string tag, input logic r, input logic en, input logic [2:0] sel);
        expT e;
        rst = r;
        ifH.enable = en; ifH.a0 = sel[0]; ifH.a1 = sel[1]; ifH.a2 = sel[2];
        ifL.enable = en; ifL.a0 = sel[0]; ifL.a1 = sel[1]; ifL.a2 = sel[2];
        e.en    = !r && en;
        e.valid = !r && en;
        e.dWord = (!r && en) ? (8'h01 << sel) : 8'h00;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        ifH.enable = 1'b0; ifH.a0 = 1'b0; ifH.a1 = 1'b0; ifH.a2 = 1'b0;
        ifL.enable = 1'b0; ifL.a0 = 1'b0; ifL.a1 = 1'b0; ifL.a2 = 1'b0;
        #2;

        // Reset held for two edges with enable=1 and sel=5.
        applyStimulus("reset0", 1'b1, 1'b1, 3'd5);
        applyStimulus("reset1", 1'b1, 1'b1, 3'd5);

        // Sweep every select value, one per cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("sweep%0d", i), 1'b0, 1'b1, 3'(i));
        end

        // Disable with non-zero selects.
        applyStimulus("dis3", 1'b0, 1'b0, 3'd3);
        applyStimulus("dis7", 1'b0, 1'b0, 3'd7);

        // Active-low spot value (sel=2 -> 8'hFB on the low instance).
        applyStimulus("sel2", 1'b0, 1'b1, 3'd2);

        // Mid-stream reset and resume.
        applyStimulus("mid_pre", 1'b0, 1'b1, 3'd6);
        applyStimulus("mid_rst", 1'b1, 1'b1, 3'd6);
        applyStimulus("mid_post", 1'b0, 1'b1, 3'd6);

        // Random enable/select.
        for (int i = 0; i < 200; i++) begin
            applyStimulus($sformatf("rand%0d", i), 1'b0, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule : tb_three_to_eight_decoder
